// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with debounce and a one-entry valid/ready output register.
// Define KEYPAD_DEBOUNCE_EN to debounce over DEB_SCANS scans; otherwise the first qualifying scan decides.
module keypad_encoder #(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun
);

    if (SCAN_DIV < 4 || DEB_SCANS < 1) begin : g_bad_params
        $error("keypad_encoder: SCAN_DIV must be >= 4 and DEB_SCANS >= 1");
    end

    localparam int DIVW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

    logic [DIVW-1:0] div_cnt;
    logic [1:0]      col_idx;
    logic [3:0]      row_s1, row_s2;
    logic [1:0]      acc_cnt, nxt_cnt;
    logic [3:0]      acc_code, nxt_code;
    logic [2:0]      n_now, tot;
    logic [1:0]      r_idx;
    logic            sample, scan_done, scan_single;
    logic [3:0]      scan_code;

    state_t          state, state_nxt;
    logic [3:0]      cand, cand_nxt;
    logic            accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    assign sample    = (div_cnt == DIVW'(SCAN_DIV - 1));
    assign scan_done = sample && (col_idx == 2'd3);

    // Fold the current column's sample into the running scan tally (count saturates at 2).
    always_comb begin
        n_now = 3'd0;
        r_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!row_s2[i]) begin
                n_now = n_now + 3'd1;
                r_idx = 2'(i);
            end
        end
        tot         = {1'b0, acc_cnt} + n_now;
        nxt_cnt     = (tot >= 3'd2) ? 2'd2 : tot[1:0];
        nxt_code    = (acc_cnt == 2'd0 && n_now == 3'd1) ? key_map(r_idx, col_idx) : acc_code;
        scan_single = (tot == 3'd1);
        scan_code   = nxt_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1   <= 4'hF;
            row_s2   <= 4'hF;
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            col      <= 4'b1110;
            acc_cnt  <= 2'd0;
            acc_code <= 4'h0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (sample) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                col     <= {col[2:0], col[3]};
                if (scan_done) begin
                    acc_cnt  <= 2'd0;
                    acc_code <= 4'h0;
                end else begin
                    acc_cnt  <= nxt_cnt;
                    acc_code <= nxt_code;
                end
            end else begin
                div_cnt <= div_cnt + DIVW'(1);
            end
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_SCANS + 1);
    logic [DW-1:0] deb_cnt, deb_nxt;

    // The scan that leaves IDLE/HELD already counts as the first of DEB_SCANS.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        deb_nxt   = deb_cnt;
        accept    = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_single) begin
                        cand_nxt = scan_code;
                        if (DEB_SCANS <= 1) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            state_nxt = PRESS_DEB;
                            deb_nxt   = DW'(1);
                        end
                    end
                end
                PRESS_DEB: begin
                    if (scan_single && scan_code == cand) begin
                        if (deb_cnt == DW'(DEB_SCANS - 1)) begin
                            accept    = 1'b1;
                            state_nxt = HELD;
                            deb_nxt   = '0;
                        end else begin
                            deb_nxt = deb_cnt + DW'(1);
                        end
                    end else begin
                        state_nxt = IDLE;
                        deb_nxt   = '0;
                    end
                end
                HELD: begin
                    if (!scan_single) begin
                        if (DEB_SCANS <= 1) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = REL_DEB;
                            deb_nxt   = DW'(1);
                        end
                    end
                end
                default: begin
                    if (!scan_single) begin
                        if (deb_cnt == DW'(DEB_SCANS - 1)) begin
                            state_nxt = IDLE;
                            deb_nxt   = '0;
                        end else begin
                            deb_nxt = deb_cnt + DW'(1);
                        end
                    end else begin
                        state_nxt = HELD;
                        deb_nxt   = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) deb_cnt <= '0;
        else     deb_cnt <= deb_nxt;
    end
`else
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        accept    = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_single) begin
                        cand_nxt  = scan_code;
                        accept    = 1'b1;
                        state_nxt = HELD;
                    end
                end
                HELD: begin
                    if (!scan_single) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cand  <= 4'h0;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
        end
    end

    // Valid/ready: key_code is held stable while key_valid=1 and is consumed on any rising
    // edge with key_valid&key_ready; key_ready is ignored while key_valid=0. A key accepted
    // while the register is full and not being consumed is dropped and flagged by overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (accept) begin
                if (!key_valid || key_ready) begin
                    key_code  <= cand_nxt;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized scoreboard bench for keypad_encoder: a physical keypad model drives row from col,
// a scan-level reference model predicts accepted keys, and a monitor checks every cycle.
module tb_keypad_encoder;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;
    localparam int SCAN_CYC  = 4 * SCAN_DIV;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int D_EFF = DEB_SCANS;
`else
    localparam int D_EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    logic [15:0] keys = '0;   // pressed set, bit index r*4+c
    int          kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [3:0]  exp_q[$];
    int          ready_mode = 0;

    int   cyc = 0;
    int   mst = 0;
    int   cnt = 0;
    int   cand = 0;
    bit   m_acc;
    int   m_code;
    logic exp_valid = 1'b0;
    logic exp_ovr = 1'b0;
    bit   mon_en = 1'b0;
    logic [3:0] exp_col;

    keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column: row r is low when a driven-low column has a key down.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] kbit(input int r, input int c);
        return 16'(1) << (r * 4 + c);
    endfunction

    // Scan-level model: one call per completed full-matrix scan.
    task automatic scan_step(input logic [15:0] k, output bit acc, output int code);
        int  n;
        int  idx;
        bit  single;
        int  sc;
        n = $countones(k);
        idx = 0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = i;
        single = (n == 1);
        sc = kmap[idx];
        acc = 0;
        case (mst)
            0: if (single) begin
                cand = sc;
                if (D_EFF == 1) begin acc = 1; mst = 2; end
                else begin mst = 1; cnt = 1; end
            end
            1: if (single && sc == cand) begin
                cnt++;
                if (cnt == D_EFF) begin acc = 1; mst = 2; end
            end else mst = 0;
            2: if (!single) begin
                if (D_EFF == 1) mst = 0;
                else begin mst = 3; cnt = 1; end
            end
            default: if (!single) begin
                cnt++;
                if (cnt == D_EFF) mst = 0;
            end else mst = 2;
        endcase
        code = cand;
    endtask

    // Reference model and expected-output register, advanced on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; mst = 0; cnt = 0; cand = 0;
            exp_valid = 1'b0; exp_ovr = 1'b0; mon_en = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            mon_en = 1'b1;
            m_acc = 0;
            m_code = 0;
            if (cyc % SCAN_CYC == 0) scan_step(keys, m_acc, m_code);
            exp_ovr = 1'b0;
            if (m_acc) begin
                if (!exp_valid || key_ready) begin
                    exp_q.push_back(4'(m_code));
                    exp_valid = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (exp_valid && key_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("col", col, exp_col);
            check("key_valid", key_valid, exp_valid);
            check("overrun", overrun, exp_ovr);
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("key_code_unexpected", key_valid, 1'b0);
                end else begin
                    check("key_code", key_code, exp_q[0]);
                    if (key_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       key_ready = 1'b0;
                1:       key_ready = 1'b1;
                default: key_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_scan(input logic [15:0] k, input int n);
        repeat (n) begin
            keys = k;
            repeat (SCAN_CYC) @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_col", col, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] k;
        int          p;
        int          a;
        int          b;
        @(negedge clk);
        do_reset(2);

        // Key 6 held with consumer stalled, then key 5 dropped behind it.
        ready_mode = 0;
        apply_scan(kbit(1, 2), 4);
        apply_scan(16'h0, 3);
        apply_scan(kbit(1, 1), 3);
        apply_scan(16'h0, 3);
        ready_mode = 1;
        apply_scan(16'h0, 1);

        // Key 5 waits unconsumed, key 9 overruns.
        ready_mode = 0;
        apply_scan(kbit(1, 1), 3);
        apply_scan(16'h0, 3);
        apply_scan(kbit(2, 2), 3);
        apply_scan(16'h0, 3);
        ready_mode = 1;
        apply_scan(16'h0, 1);

        // Key E consumed immediately, single event while held.
        apply_scan(kbit(3, 0), 4);
        apply_scan(16'h0, 3);

        // Two keys at once never produce a key.
        apply_scan(kbit(0, 0) | kbit(2, 1), 4);
        apply_scan(16'h0, 2);

        // Key 8 for a single scan, then released.
        apply_scan(kbit(2, 1), 1);
        apply_scan(16'h0, 3);

        // Reset in the middle of debouncing key 2, key kept down.
        keys = kbit(0, 1);
        repeat (SCAN_CYC + 6) @(posedge clk);
        @(negedge clk);
        do_reset(1);
        apply_scan(kbit(0, 1), 4);
        apply_scan(16'h0, 3);

        // Random keys, durations and consumer stalls.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            p = $urandom_range(0, 99);
            if (p < 40) begin
                k = 16'h0;
            end else if (p < 80) begin
                k = 16'(1) << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k = (16'(1) << a) | (16'(1) << b);
            end
            apply_scan(k, $urandom_range(1, 4));
        end

        ready_mode = 1;
        apply_scan(16'h0, 3);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
